svd_result_reader: RTL and testbench

Consumer end of the svd8x4 result interface. It detects the rising edge of en_out_svd and snapshots the three packed 384-bit result buses (A, U, V). It then streams them element by element over a valid/ready port to the downstream host or bus bridge. This frees the SVD core and lets a slow consumer drain results under back-pressure.

---
 rtl/svd_result_reader.sv | 125 ++++++++++++
 tb/tb_svd_result_reader.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/svd_result_reader.sv
// Snapshots the svd8x4 A/U/V result buses on a rising en_out_svd and
// streams them as 48 valid/ready beats (A0..A15, U0..U15, V0..V15).
module svd_result_reader #(
  parameter int data_width  = 24,
  parameter int n_elem      = 16,
  parameter int data_cordic = n_elem * data_width
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [data_cordic-1:0] data_out_A,
  input  logic [data_cordic-1:0] data_out_U,
  input  logic [data_cordic-1:0] data_out_V,
  input  logic                   en_out_svd,
  input  logic                   out_ready,
  input  logic                   clr_overrun,
  output logic [data_width-1:0]  out_data,
  output logic                   out_valid,
  output logic [1:0]             out_sel,
  output logic [3:0]             out_idx,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

  localparam logic [3:0] LAST_IDX = 4'(n_elem - 1);

  state_t                      r_state;
  logic                        r_en_prev;
  logic [2:0][data_cordic-1:0] r_shadow;
  logic [1:0]                  r_sel;
  logic [3:0]                  r_idx;
  logic                        r_valid, r_busy, r_done, r_overrun;

  logic                   w_start, w_xfer, w_ovr_evt;
  logic [data_cordic-1:0] w_bus;
  logic [data_width-1:0]  w_elem;

  assign w_start   = en_out_svd & ~r_en_prev;
  assign w_xfer    = r_valid & out_ready;
  assign w_ovr_evt = w_start & (r_state != S_IDLE);

  always_comb begin
    w_bus = '0;
    case (r_sel)
      2'd0:    w_bus = r_shadow[0];
      2'd1:    w_bus = r_shadow[1];
      2'd2:    w_bus = r_shadow[2];
      default: w_bus = '0;
    endcase
  end

  assign w_elem    = w_bus[r_idx*data_width +: data_width];
  // Outputs decode purely from registered state, so they hold while stalled.
  assign out_data  = r_valid ? w_elem : '0;
  assign out_last  = r_valid & (r_sel == 2'd2) & (r_idx == LAST_IDX);
  assign out_valid = r_valid;
  assign out_sel   = r_sel;
  assign out_idx   = r_idx;
  assign busy      = r_busy;
  assign done      = r_done;
  assign overrun   = r_overrun;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_en_prev <= 1'b0;
      r_sel     <= 2'd0;
      r_idx     <= 4'd0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_en_prev <= en_out_svd;
      r_done    <= 1'b0;
      // A new result while busy wins over a same-cycle clear.
      if (w_ovr_evt)        r_overrun <= 1'b1;
      else if (clr_overrun) r_overrun <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_shadow[0] <= data_out_A;
            r_shadow[1] <= data_out_U;
            r_shadow[2] <= data_out_V;
            r_sel       <= 2'd0;
            r_idx       <= 4'd0;
            r_valid     <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_SEND;
          end
        end
        S_SEND: begin
          if (r_sel == 2'd3) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_xfer) begin
            if (r_idx != LAST_IDX) begin
              r_idx <= r_idx + 4'd1;
            end else if (r_sel != 2'd2) begin
              r_idx <= 4'd0;
              r_sel <= r_sel + 2'd1;
            end else begin
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_svd_result_reader.sv
// Randomised and directed bench for svd_result_reader against a queue-based
// model of the expected beat stream, done pulse and sticky overrun.
module tb_svd_result_reader;
  localparam int DW = 24;
  localparam int NE = 16;
  localparam int DC = NE * DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, en, rdy, clr;
  logic [DC-1:0] bA, bU, bV;
  logic [DW-1:0] out_data;
  logic          out_valid, out_last, busy, done, overrun;
  logic [1:0]    out_sel;
  logic [3:0]    out_idx;

  svd_result_reader #(.data_width(DW), .n_elem(NE)) dut (
    .clk(clk), .rst_n(rst_n),
    .data_out_A(bA), .data_out_U(bU), .data_out_V(bV),
    .en_out_svd(en), .out_ready(rdy), .clr_overrun(clr),
    .out_data(out_data), .out_valid(out_valid), .out_sel(out_sel),
    .out_idx(out_idx), .out_last(out_last), .busy(busy), .done(done),
    .overrun(overrun)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [1:0]    s;
    logic [3:0]    k;
  } beat_t;

  beat_t q[$];
  bit    m_en_prev, m_done, m_ovr;
  int    hs;
  int    n_vec = 0;
  int    n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DC-1:0] pat(input logic [DW-1:0] base);
    logic [DC-1:0] p;
    for (int k = 0; k < NE; k++) p[k*DW +: DW] = base + DW'(k);
    return p;
  endfunction

  // Model: a frame is a list of 48 beats captured at the start edge; the
  // head of the list is what must be on the port.
  task automatic model_step();
    bit start, was_done, busyish;
    beat_t b;
    if (!rst_n) begin
      q.delete();
      m_done = 0; m_ovr = 0; m_en_prev = 0;
      return;
    end
    start     = en && !m_en_prev;
    m_en_prev = en;
    was_done  = m_done;
    m_done    = 0;
    busyish   = (q.size() > 0) || was_done;
    if (start && busyish) m_ovr = 1;
    else if (clr)         m_ovr = 0;
    if (q.size() > 0) begin
      if (rdy) begin
        void'(q.pop_front());
        hs++;
        if (q.size() == 0) m_done = 1;
      end
    end else if (!was_done && start) begin
      for (int s = 0; s < 3; s++)
        for (int k = 0; k < NE; k++) begin
          b.s = 2'(s);
          b.k = 4'(k);
          b.d = (s == 0) ? bA[k*DW +: DW] : (s == 1) ? bU[k*DW +: DW] : bV[k*DW +: DW];
          q.push_back(b);
        end
    end
  endtask

  task automatic compare();
    bit v;
    v = q.size() > 0;
    chk("out_valid", 32'(out_valid), 32'(v));
    chk("busy", 32'(busy), 32'(v));
    chk("done", 32'(done), 32'(m_done));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("out_last", 32'(out_last), 32'(q.size() == 1));
    if (v) begin
      chk("out_data", 32'(out_data), 32'(q[0].d));
      chk("out_sel", 32'(out_sel), 32'(q[0].s));
      chk("out_idx", 32'(out_idx), 32'(q[0].k));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic wait_hs(input int n);
    int b = 0;
    while (hs < n && b < 400) begin tick(); b++; end
    if (hs < n) begin
      n_vec++; n_bad++;
      $display("FAIL wait_hs: got %0d handshakes expected %0d", hs, n);
    end
  endtask

  task automatic drain();
    int b = 0;
    while ((q.size() > 0 || m_done) && b < 400) begin tick(); b++; end
    if (b >= 400) begin
      n_vec++; n_bad++;
      $display("FAIL drain: frame did not finish, %0d beats left", q.size());
    end
    tick();
  endtask

  task automatic load_pattern();
    bA = pat(24'h0A0000); bU = pat(24'h0B0000); bV = pat(24'h0C0000);
  endtask

  logic [3:0] rp;

  initial begin
    rst_n = 0; en = 0; rdy = 1; clr = 0; hs = 0;
    m_en_prev = 0; m_done = 0; m_ovr = 0;
    load_pattern();
    tick(); tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_sel", 32'(out_sel), 32'd0);
    chk("rst_idx", 32'(out_idx), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    rst_n = 1; tick();

    // Full-rate frame
    hs = 0; en = 1; tick(); en = 0;
    chk("first_beat", 32'(out_data), 32'h0A0000);
    wait_hs(47);
    chk("last_flag", 32'(out_last), 32'd1);
    chk("last_data", 32'(out_data), 32'h0C000F);
    tick();
    chk("done_pulse", 32'(done), 32'd1);
    chk("hs_full", 32'(hs), 32'd48);
    tick();
    chk("done_low", 32'(done), 32'd0);
    chk("busy_after", 32'(busy), 32'd0);

    // Back-pressure 1,0,0,1
    rp = 4'b1001;
    hs = 0; en = 1; tick(); en = 0;
    for (int c = 0; c < 400 && q.size() > 0; c++) begin rdy = rp[c%4]; tick(); end
    rdy = 1;
    chk("hs_stall", 32'(hs), 32'd48);
    drain();

    // Buses change right after capture
    hs = 0; en = 1; tick(); en = 0;
    bA = '1; bU = '1; bV = '1;
    tick();
    chk("snap_beat1", 32'(out_data), 32'h0A0001);
    drain();
    load_pattern();

    // Overrun at beat 10, then clear
    hs = 0; en = 1; tick(); en = 0;
    wait_hs(10);
    en = 1; tick(); en = 0;
    chk("ovr_set", 32'(overrun), 32'd1);
    drain();
    chk("hs_ovr", 32'(hs), 32'd48);
    chk("ovr_sticky", 32'(overrun), 32'd1);
    clr = 1; tick(); clr = 0;
    chk("ovr_clr", 32'(overrun), 32'd0);

    // en held high: no retrigger
    hs = 0; en = 1; tick();
    drain();
    repeat (10) tick();
    chk("hold_no_frame", 32'(out_valid), 32'd0);
    chk("hold_no_ovr", 32'(overrun), 32'd0);
    en = 0; tick(); en = 1; tick();
    chk("retrig_valid", 32'(out_valid), 32'd1);
    chk("retrig_data", 32'(out_data), 32'h0A0000);
    en = 0;
    drain();

    // Reset mid-frame at beat 20
    hs = 0; en = 1; tick(); en = 0;
    wait_hs(15);
    en = 1; tick(); en = 0;
    wait_hs(20);
    rst_n = 0; tick(); rst_n = 1;
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_ovr", 32'(overrun), 32'd0);
    tick(); tick();
    hs = 0; en = 1; tick(); en = 0;
    chk("restart_data", 32'(out_data), 32'h0A0000);
    chk("restart_sel", 32'(out_sel), 32'd0);
    chk("restart_idx", 32'(out_idx), 32'd0);
    drain();

    // Randomised traffic
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < NE; k++) begin
        bA[k*DW +: DW] = DW'($urandom);
        bU[k*DW +: DW] = DW'($urandom);
        bV[k*DW +: DW] = DW'($urandom);
      end
      for (int c = 0; c < 250; c++) begin
        en  = ($urandom_range(0, 15) == 0);
        rdy = $urandom_range(0, 1) == 1;
        clr = ($urandom_range(0, 7) == 0);
        tick();
      end
    end
    en = 0; rdy = 1; clr = 0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
